// File: rtl/breakout_pkg.sv
// Shared constants and types for the breakout game datapath.
package breakout_pkg;

    // Screen geometry.
    localparam int H_RES          = 640;
    localparam int V_RES          = 480;

    // Paddle geometry and start position.
    localparam int PADDLE_HALF_W  = 40;
    localparam int PADDLE_RESET_X = 320;
    localparam int PADDLE_Y       = 460;
    localparam int PADDLE_HEIGHT  = 8;

    // 3-bit RGB colours written to the VGA plotter.
    localparam logic [2:0] COLOUR_FG = 3'b111;
    localparam logic [2:0] COLOUR_BG = 3'b000;

    // Paddle renderer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_DONE
    } render_state_t;

endpackage

// File: rtl/paddle_rect_scan.sv
// Column/row scanner for one paddle rectangle. Columns are carried in
// 11 bits so a paddle hanging off the left edge appears as a large
// unsigned value, which the renderer treats as off-screen.
module paddle_rect_scan #(
    parameter int HALF_W   = breakout_pkg::PADDLE_HALF_W,
    parameter int HEIGHT   = breakout_pkg::PADDLE_HEIGHT,
    parameter int PADDLE_Y = breakout_pkg::PADDLE_Y
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [9:0]  cx,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [10:0] col_nxt,
    output logic        last
);

    localparam logic [8:0] ROW_FIRST = 9'(PADDLE_Y);
    localparam logic [8:0] ROW_LAST  = 9'(PADDLE_Y + HEIGHT - 1);

    logic [10:0] col_q;
    logic [10:0] col_first_q;
    logic [10:0] col_end_q;
    logic [10:0] ld_first;
    logic [10:0] ld_last;
    logic        col_end_hit;

    assign ld_first    = {1'b0, cx} - 11'(HALF_W);
    assign ld_last     = {1'b0, cx} + 11'(HALF_W - 1);
    assign col_end_hit = (col_q == col_end_q);
    assign last        = col_end_hit && (y == ROW_LAST);
    assign x           = col_q[9:0];

    // Column the scanner will hold after this edge; lets the renderer
    // register the matching plot-enable in the same cycle.
    always_comb begin
        col_nxt = col_q;
        if (load) begin
            col_nxt = ld_first;
        end else if (step) begin
            col_nxt = col_end_hit ? col_first_q : col_q + 11'd1;
        end
    end

    // Column counter wraps to the left edge at row end; row counter follows.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q       <= '0;
            col_first_q <= '0;
            col_end_q   <= '0;
            y           <= '0;
        end else if (load) begin
            col_q       <= ld_first;
            col_first_q <= ld_first;
            col_end_q   <= ld_last;
            y           <= ROW_FIRST;
        end else if (step) begin
            col_q <= col_nxt;
            if (col_end_hit) begin
                y <= y + 9'd1;
            end
        end
    end

endmodule

// File: rtl/paddle_render.sv
// Paddle renderer: on each frame tick erases the old paddle rectangle and
// draws the new one through the VGA plotter's pixel-write handshake.
module paddle_render #(
    parameter int         H_RES     = breakout_pkg::H_RES,
    parameter int         PADDLE_Y  = breakout_pkg::PADDLE_Y,
    parameter int         HALF_W    = breakout_pkg::PADDLE_HALF_W,
    parameter int         HEIGHT    = breakout_pkg::PADDLE_HEIGHT,
    parameter logic [2:0] FG_COLOUR = breakout_pkg::COLOUR_FG,
    parameter logic [2:0] BG_COLOUR = breakout_pkg::COLOUR_BG
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [9:0] paddle_x,
    input  logic       ready,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    import breakout_pkg::*;

    render_state_t state;
    logic [9:0]    new_x;
    logic [9:0]    old_x;
    logic          old_valid;

    logic          adv;
    logic          scan_load;
    logic          scan_step;
    logic [9:0]    scan_cx;
    logic [10:0]   col_nxt;
    logic          scan_last;

    // Off-screen columns (including negative ones, which wrap high) are
    // scanned but never presented to the plotter.
    function automatic logic in_range(input logic [10:0] c);
        return c < 11'(H_RES);
    endfunction

    paddle_rect_scan #(
        .HALF_W   (HALF_W),
        .HEIGHT   (HEIGHT),
        .PADDLE_Y (PADDLE_Y)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .load    (scan_load),
        .step    (scan_step),
        .cx      (scan_cx),
        .x       (x),
        .y       (y),
        .col_nxt (col_nxt),
        .last    (scan_last)
    );

    // Scanner control: a suppressed pixel advances without waiting on ready.
    always_comb begin
        adv       = ((state == ST_ERASE) || (state == ST_DRAW)) && (!plot || ready);
        scan_load = 1'b0;
        scan_step = 1'b0;
        scan_cx   = new_x;
        unique case (state)
            ST_IDLE: begin
                if (start && !(old_valid && (paddle_x == old_x))) begin
                    scan_load = 1'b1;
                    scan_cx   = old_valid ? old_x : paddle_x;
                end
            end
            ST_ERASE: begin
                if (adv) begin
                    if (scan_last) begin
                        scan_load = 1'b1;
                        scan_cx   = new_x;
                    end else begin
                        scan_step = 1'b1;
                    end
                end
            end
            ST_DRAW: begin
                if (adv && !scan_last) begin
                    scan_step = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer with registered plot/colour/busy/done outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            new_x     <= '0;
            old_x     <= '0;
            old_valid <= 1'b0;
            colour    <= BG_COLOUR;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        new_x <= paddle_x;
                        if (old_valid && (paddle_x == old_x)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= old_valid ? ST_ERASE : ST_DRAW;
                            colour <= old_valid ? BG_COLOUR : FG_COLOUR;
                            plot   <= in_range(col_nxt);
                            busy   <= 1'b1;
                        end
                    end
                end
                ST_ERASE: begin
                    if (adv) begin
                        plot <= in_range(col_nxt);
                        if (scan_last) begin
                            state  <= ST_DRAW;
                            colour <= FG_COLOUR;
                        end
                    end
                end
                ST_DRAW: begin
                    if (adv) begin
                        if (scan_last) begin
                            state     <= ST_DONE;
                            plot      <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            old_x     <= new_x;
                            old_valid <= 1'b1;
                        end else begin
                            plot <= in_range(col_nxt);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_render.sv
// Scoreboard bench for paddle_render: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every accepted plot.
module tb_paddle_render;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } pix_t;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [9:0] paddle_x;
    logic       ready;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    pix_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ncnt = 0;
    int   xfers = 0;
    int   last_xfer_ng = 0;
    int   done_seen = 0;
    int   done_ng = 0;
    bit   stall = 0;
    bit   model_valid = 0;
    int   model_old = 0;

    bit   prev_ok = 0;
    logic prev_plot = 0;
    logic prev_ready = 0;
    int   prev_word = 0;

    paddle_render dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .paddle_x (paddle_x),
        .ready    (ready),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_rect(input int cx, input logic [2:0] c);
        for (int r = 460; r < 468; r++) begin
            for (int col = cx - 40; col < cx + 40; col++) begin
                if (col >= 0 && col < 640) begin
                    exp_q.push_back('{x: 10'(col), y: 9'(r), c: c});
                end
            end
        end
    endtask

    // Monitor: sample between active edges.
    always @(negedge clk) begin
        pix_t e;
        ncnt++;
        if (!resetn) begin
            prev_ok = 0;
        end else begin
            if (prev_ok && prev_plot && !prev_ready)
                check("stall_hold", int'({plot, x, y, colour}), prev_word);
            if (plot && ready) begin
                xfers++;
                last_xfer_ng = ncnt;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_pixel: got x=%0d y=%0d colour=%0d, expected no pixel",
                             x, y, colour);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_x", int'(x), int'(e.x));
                    check("pix_y", int'(y), int'(e.y));
                    check("pix_colour", int'(colour), int'(e.c));
                end
            end
            if (done) begin
                done_seen++;
                done_ng = ncnt;
                check("done_plot_low", int'(plot), 0);
                check("done_busy_low", int'(busy), 0);
            end
            prev_ok    = 1;
            prev_plot  = plot;
            prev_ready = ready;
            prev_word  = int'({plot, x, y, colour});
        end
    end

    // exp_cyc < 0 means: done must follow the last transfer by one cycle.
    task automatic do_update(input logic [9:0] px, input int exp_cyc,
                             input int exp_xfers, input bit poke, input string tag);
        int s;
        int d0;
        int x0;
        if (!(model_valid && int'(px) == model_old)) begin
            if (model_valid) push_rect(model_old, 3'b000);
            push_rect(int'(px), 3'b111);
            model_old   = int'(px);
            model_valid = 1;
        end
        @(posedge clk);
        #1;
        paddle_x = px;
        start    = 1'b1;
        s        = ncnt + 1;
        d0       = done_seen;
        x0       = xfers;
        @(posedge clk);
        #1;
        start    = 1'b0;
        paddle_x = px ^ 10'h155;
        if (poke) begin
            repeat (50) @(posedge clk);
            #1;
            start    = 1'b1;
            paddle_x = 10'd5;
            @(posedge clk);
            #1;
            start    = 1'b0;
        end
        for (int i = 0; i < 10000 && done_seen == d0; i++) @(posedge clk);
        if (done_seen == d0) begin
            check({tag, "_timeout"}, 0, 1);
        end else if (exp_cyc >= 0) begin
            check({tag, "_done_cycle"}, done_ng - s, exp_cyc);
        end else begin
            check({tag, "_done_after_last"}, done_ng - last_xfer_ng, 1);
        end
        check({tag, "_done_count"}, done_seen - d0, 1);
        check({tag, "_transfers"}, xfers - x0, exp_xfers);
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_y"}, int'(y), 0);
        check({tag, "_colour"}, int'(colour), 0);
        check({tag, "_plot"}, int'(plot), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        paddle_x = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        resetn = 1'b1;

        // First update after reset: draw only, 640 pixels.
        do_update(10'd320, 641, 640, 0, "first");
        // One-pixel move: full erase then full draw.
        do_update(10'd321, 1281, 1280, 0, "move");
        // Same position: nothing plotted.
        do_update(10'd321, 1, 0, 0, "nomove");
        // Stalled move, with a start poked mid-update that must be ignored.
        stall = 1;
        do_update(10'd400, -1, 1280, 1, "stall");
        stall = 0;
        // Right-edge clip: draw at 580..659 gives 60 visible per row.
        do_update(10'd620, 1281, 640 + 480, 0, "clip");

        // Reset during DRAW (erase of 620 is 640 cycles long).
        if (model_valid) push_rect(model_old, 3'b000);
        push_rect(100, 3'b111);
        @(posedge clk);
        #1;
        paddle_x = 10'd100;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        check("pre_reset_busy", int'(busy), 1);
        resetn = 1'b0;
        exp_q.delete();
        model_valid = 0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // After reset: draw only, left-edge clip (cols -30..49 -> 50 per row).
        do_update(10'd10, 641, 400, 0, "postrst");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
